// File: rtl/uart_rx_to_mem.sv
`default_nettype none
// uart_rx_to_mem: UART receiver that pairs bytes (low first) into 16-bit memory writes.
// Define RXMEM_PARITY_EN for 8E1 framing with parity checking; default is 8N1.
module uart_rx_to_mem #(
  parameter int row          = 2,
  parameter int column       = 2,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_data,
  input  logic        load_start,
  output logic        write_R,
  output logic [31:0] write_address_R,
  output logic [15:0] write_value_R,
  output logic        load_done,
  output logic        frame_err,
  output logic        parity_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [31:0]   N_ELEM    = 32'(row * column);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} bit_state_t;
  typedef enum logic {P_LOW, P_HIGH} pair_state_t;

  logic rx_meta, rx_sync;
  bit_state_t  bit_state, bit_nxt;
  pair_state_t pair_state, pair_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  low_byte, low_nxt;
  logic [31:0] count, count_nxt;
  logic [31:0] addr_nxt;
  logic [15:0] val_nxt;
  logic        wr_nxt, done_nxt, byte_valid, tick, full, par_ok;

`ifdef RXMEM_PARITY_EN
  logic par_bad, par_bad_nxt;
  assign par_ok = !par_bad;
`else
  assign par_ok = 1'b1;
`endif

  assign tick = (timer == BIT_LAST);
  assign full = (count == N_ELEM);

  always_comb begin
    bit_nxt    = bit_state;
    timer_nxt  = timer + T_ONE;
    idx_nxt    = bit_idx;
    shift_nxt  = shift;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
`ifdef RXMEM_PARITY_EN
    par_bad_nxt = par_bad;
`endif
    case (bit_state)
      S_IDLE: begin
        timer_nxt = '0;
        if (!rx_sync) bit_nxt = S_START;
      end
      S_START: begin
        // Mid-start resample: a line already high again was a glitch.
        if (timer == HALF_LAST) begin
          timer_nxt = '0;
          idx_nxt   = 3'd0;
          bit_nxt   = rx_sync ? S_IDLE : S_DATA;
`ifdef RXMEM_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_nxt = '0;
          shift_nxt = {rx_sync, shift[7:1]};
          idx_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef RXMEM_PARITY_EN
            bit_nxt = S_PARITY;
`else
            bit_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef RXMEM_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          timer_nxt   = '0;
          bit_nxt     = S_STOP;
          par_bad_nxt = (rx_sync != ^shift);
          parity_err  = (rx_sync != ^shift);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          timer_nxt  = '0;
          bit_nxt    = S_IDLE;
          byte_valid = rx_sync && par_ok;
          frame_err  = !rx_sync;
        end
      end
      default: bit_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pair_nxt  = pair_state;
    low_nxt   = low_byte;
    count_nxt = count;
    wr_nxt    = 1'b0;
    addr_nxt  = write_address_R;
    val_nxt   = write_value_R;
    done_nxt  = load_done || full;
    if (frame_err || parity_err) begin
      pair_nxt = P_LOW;
    end else if (byte_valid && !full) begin
      if (pair_state == P_LOW) begin
        low_nxt  = shift;
        pair_nxt = P_HIGH;
      end else begin
        wr_nxt    = 1'b1;
        addr_nxt  = count;
        val_nxt   = {shift, low_byte};
        count_nxt = count + 32'd1;
        pair_nxt  = P_LOW;
      end
    end
    // A coincident write still lands at the old address; only the count restarts.
    if (load_start) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
      pair_nxt  = P_LOW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta         <= 1'b1;
      rx_sync         <= 1'b1;
      bit_state       <= S_IDLE;
      pair_state      <= P_LOW;
      timer           <= '0;
      bit_idx         <= 3'd0;
      shift           <= 8'd0;
      low_byte        <= 8'd0;
      count           <= 32'd0;
      write_R         <= 1'b0;
      write_address_R <= 32'd0;
      write_value_R   <= 16'd0;
      load_done       <= 1'b0;
`ifdef RXMEM_PARITY_EN
      par_bad         <= 1'b0;
`endif
    end else begin
      rx_meta         <= rx_data;
      rx_sync         <= rx_meta;
      bit_state       <= bit_nxt;
      pair_state      <= pair_nxt;
      timer           <= timer_nxt;
      bit_idx         <= idx_nxt;
      shift           <= shift_nxt;
      low_byte        <= low_nxt;
      count           <= count_nxt;
      write_R         <= wr_nxt;
      write_address_R <= addr_nxt;
      write_value_R   <= val_nxt;
      load_done       <= done_nxt;
`ifdef RXMEM_PARITY_EN
      par_bad         <= par_bad_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_to_mem.sv
`default_nettype none
// tb_uart_rx_to_mem: directed bench, 16 clocks per bit, 2x2 matrix.
module tb_uart_rx_to_mem;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_data = 1'b1;
  logic        load_start = 1'b0;
  logic        write_R;
  logic [31:0] write_address_R;
  logic [15:0] write_value_R;
  logic        load_done;
  logic        frame_err;
  logic        parity_err;

  uart_rx_to_mem #(.row(2), .column(2), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .load_start(load_start),
    .write_R(write_R), .write_address_R(write_address_R), .write_value_R(write_value_R),
    .load_done(load_done), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  logic [47:0] wq[$];
  int fe_cnt = 0;
  int pe_cnt = 0;

  always @(negedge clk) begin
    if (write_R) wq.push_back({write_address_R, write_value_R});
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  int tests = 0;
  int failed = 0;
  int rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_data = b;
    cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b = 1'b1, input logic par_flip = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RXMEM_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
    rx_data = 1'b1;
    cyc(2);
  endtask

  task automatic expect_write(input string name, input logic [31:0] addr, input logic [15:0] val);
    logic [47:0] e;
    chk({name, "_nwr"}, 32'(wq.size() - rd), 32'd1);
    if (wq.size() > rd) begin
      e = wq[rd];
      chk({name, "_addr"}, e[47:16], addr);
      chk({name, "_val"}, {16'd0, e[15:0]}, {16'd0, val});
    end
    rd = wq.size();
  endtask

  task automatic expect_no_write(input string name);
    chk({name, "_nwr"}, 32'(wq.size() - rd), 32'd0);
    rd = wq.size();
  endtask

  task automatic pulse_load_start;
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
    cyc(1);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [31:0] addr;
    logic [15:0] val;
    logic        done;
  } vec_t;

  vec_t vecs[4];
  int   fe0;
  int   pe0;

  initial begin
    vecs[0] = '{8'h34, 8'h12, 32'd0, 16'h1234, 1'b0};
    vecs[1] = '{8'h78, 8'h56, 32'd1, 16'h5678, 1'b0};
    vecs[2] = '{8'hBC, 8'h9A, 32'd2, 16'h9ABC, 1'b0};
    vecs[3] = '{8'hF0, 8'hDE, 32'd3, 16'hDEF0, 1'b1};

    cyc(5);
    rst = 1'b1;
    cyc(3);
    chk("rst_write_R", {31'd0, write_R}, 32'd0);
    chk("rst_addr", write_address_R, 32'd0);
    chk("rst_value", {16'd0, write_value_R}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].lo);
      send_byte(vecs[i].hi);
      cyc(4);
      expect_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].val);
      chk($sformatf("vec%0d_done", i), {31'd0, load_done}, {31'd0, vecs[i].done});
    end

    // Full matrix: traffic ignored until re-armed.
    send_byte(8'h11);
    send_byte(8'h22);
    cyc(4);
    expect_no_write("full_ignore");
    chk("full_done_held", {31'd0, load_done}, 32'd1);
    pulse_load_start();
    chk("rearm_done_clr", {31'd0, load_done}, 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    cyc(4);
    expect_write("rearm", 32'd0, 16'h2211);
    chk("rearm_done", {31'd0, load_done}, 32'd0);

    // Framing error drops the pending low byte.
    pulse_load_start();
    fe0 = fe_cnt;
    send_byte(8'hAA, 1'b0);
    cyc(CPB);
    chk("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    cyc(4);
    expect_write("ferr_pair", 32'd0, 16'h0201);

    // Short low glitch on an idle line.
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    rx_data = 1'b0;
    cyc(4);
    rx_data = 1'b1;
    cyc(3 * CPB);
    expect_no_write("glitch");
    chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("glitch_perr", 32'(pe_cnt - pe0), 32'd0);
    send_byte(8'h03);
    send_byte(8'h04);
    cyc(4);
    expect_write("post_glitch", 32'd1, 16'h0403);

    // Reset in the middle of the high byte's data bits.
    send_byte(8'h77);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_data = 1'b1;
    rst = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(3 * CPB);
    expect_no_write("mid_rst");
    send_byte(8'h05);
    send_byte(8'h00);
    cyc(4);
    expect_write("post_rst", 32'd0, 16'h0005);

`ifdef RXMEM_PARITY_EN
    pulse_load_start();
    pe0 = pe_cnt;
    send_byte(8'h03, 1'b1, 1'b1);
    cyc(4);
    chk("perr_pulses", 32'(pe_cnt - pe0), 32'd1);
    expect_no_write("perr_drop");
    send_byte(8'h03);
    send_byte(8'h00);
    cyc(4);
    expect_write("perr_pair", 32'd0, 16'h0003);
`else
    chk("no_parity_err", 32'(pe_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
